uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive path of the board UART, the receiving counterpart of the transmit FIFO on the same link. Synchronises the incoming `rx` line and recovers 8N1 frames using 16x oversampling. Pushes each good byte into a small FIFO that the host logic drains with an active-low read strobe. Carries the same link format and the same pin-style handshake as the transmit side, so a loopback of `tx` to `rx` returns the written bytes.

## Interface
- `DVSR`, 27: clocks per 16x oversample tick. One bit time is 16*DVSR clocks; the default gives 115200 baud at 50 MHz.
- `DBIT`, 8: data bits per frame, sent LSB first.
- `SB_TICK`, 16: oversample ticks in the stop bit.
- `ADDR_W`, 2: FIFO address width; depth is 2^ADDR_W entries.
- `clk` in 1: single system clock, rising edge.
- `reset_pin` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `rd_rx_pin` in 1: active-low read strobe. Each high-to-low transition pops one entry.
- `r_data` out DBIT: FIFO head, first-word-fall-through. Valid while `rx_empty`=0.
- `rx_empty` out 1: FIFO holds no entries.
- `rx_full` out 1: FIFO holds 2^ADDR_W entries.
- `rx_busy` out 1: receiver FSM is not in IDLE.
- `frame_err` out 1: sticky; set when a stop bit is sampled low.
- `overrun` out 1: sticky; set when a good byte is dropped because the FIFO is full.

## Operation
- `rx` and `rd_rx_pin` each pass through a 2-flop synchroniser; the synchroniser flops reset to 1.
- Tick counter runs free from 0 to DVSR-1. `tick` pulses for one clock when the count equals DVSR-1.
- FSM states: IDLE, START, DATA, STOP. Sample counter `s` is 4 bits; bit counter `n` is log2(DBIT) bits.
- IDLE: a synchronised `rx`=0 moves to START with s=0.
- START: `s` advances on each tick. At s=7, if `rx`=0, go to DATA with s=0 and n=0. If `rx`=1, treat it as a glitch and return to IDLE; nothing is pushed and no flag is set.
- DATA: at s=15 on a tick, shift right into `b` (`b`={rx, b[DBIT-1:1]}), reset s to 0 and increment n. After bit DBIT-1, go to STOP.
- STOP: at s=SB_TICK-1 on a tick, go to IDLE.
  - If `rx`=1, raise a one-cycle `rx_done` carrying `b`.
  - If `rx`=0, set `frame_err` and discard the byte.
- Push: `rx_done` and not full. If full with no pop in the same cycle, drop the byte and set `overrun`.
- Pop: a synchronised falling edge of `rd_rx_pin` while not empty. A pop while empty is ignored.
- Simultaneous push and pop:
  - not empty and not full: both happen and the count is unchanged;
  - empty: only the push happens;
  - full: both happen, with no overrun.
- Pointers wrap modulo 2^ADDR_W. `rx_full` and `rx_empty` come from a registered count of width ADDR_W+1.
- The sticky flags clear only on reset.

## Timing
- Reset values: `r_data`=0, `rx_empty`=1, `rx_full`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0. The FSM is in IDLE, and the pointers and all counters are 0.
- Reset asserted mid-frame aborts the frame, discards the partial byte and empties the FIFO.
- `rx_busy` rises 3 clocks after the `rx` falling edge: 2 synchroniser clocks plus 1 FSM transition.
- Data bits are sampled about 8+16k ticks after the detected start edge, with ±1 tick of jitter.
- `rx_done` occurs in the clock of the stop-bit tick. On the next edge `rx_empty` falls, `r_data` is valid, and `rx_busy` falls.
- `rd_rx_pin` falling edge to pop takes 3 clocks: 2 synchroniser clocks plus the edge detector. `r_data` shows the next entry on that same edge.

## Structure
- Put the shared UART constants in a common defines file used by both the tx and rx sides: state encodings, default DVSR, DBIT and SB_TICK.
- Use one sub-module, `uart_rx_core`: `rx` synchroniser, tick counter, FSM and shift register. It outputs `rx_done`, `dout` and `frame_err`.
- The FIFO, the `rd_rx_pin` synchroniser and edge detector, and the overrun logic live in the top level.

## Test plan
Benches run with DVSR=4, so one bit is 64 clocks.
- Reset, then a frame carrying 0x41 → after the stop bit `rx_empty`=0 and `r_data`=0x41. One `rd_rx_pin` low pulse → `rx_empty`=1.
- Back-to-back frames 0x08, 0x28, 0xFF, 0x00 with no reads → `rx_full`=1 and `overrun`=0. Four pops return the bytes in that order.
- With the FIFO full, a fifth frame 0x55 → `overrun`=1 and 0x55 is never popped. A pop during the frame's stop bit instead accepts 0x55 with no overrun.
- A 3-tick low glitch on `rx` → FSM returns to IDLE; `rx_empty` stays 1 and `frame_err` stays 0.
- Frame 0xA5 with the stop bit driven low → `frame_err`=1 and the FIFO stays empty.
- `reset_pin` low during the data bits of 0x3C → all outputs return to reset values immediately. The next clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART link constants: FSM state encoding and default frame/baud settings.
// Used by both the transmit and receive sides of the board UART.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DVSR        = 27;
    localparam int unsigned UART_DBIT        = 8;
    localparam int unsigned UART_SB_TICK     = 16;
    localparam int unsigned UART_ADDR_W      = 2;
    localparam int unsigned UART_S_W         = 4;
    localparam int unsigned UART_MID_SAMPLE  = 7;
    localparam int unsigned UART_LAST_SAMPLE = 15;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: rx synchroniser, 16x oversample tick generator, frame FSM and shift register.
// rx_done_c pulses in the stop-bit tick cycle with the byte on dout.
module uart_rx_core
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DVSR    = UART_DVSR,
    parameter int unsigned DBIT    = UART_DBIT,
    parameter int unsigned SB_TICK = UART_SB_TICK
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    output logic            rx_done_c,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            rx_busy
);

    localparam int unsigned CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            rx_s1_q, rx_s2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_c;
    uart_state_e     state_q, state_d;
    logic [UART_S_W-1:0] s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;

    // Free-running oversample divider
    always_comb begin
        tick_c = (cnt_q == CW'(DVSR - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        ferr_d    = ferr_q;
        rx_done_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s2_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (s_q == UART_S_W'(UART_MID_SAMPLE)) begin
                        // A start bit that is high again at mid-bit was only a glitch
                        state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + UART_S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (s_q == UART_S_W'(UART_LAST_SAMPLE)) begin
                        b_d = {rx_s2_q, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + UART_S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (s_q == UART_S_W'(SB_TICK - 1)) begin
                        state_d = ST_IDLE;
                        if (rx_s2_q) begin
                            rx_done_c = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + UART_S_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign dout      = b_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: receiver core feeding a first-word-fall-through FIFO
// drained by a synchronised active-low read strobe; sticky overrun on drop.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DVSR    = UART_DVSR,
    parameter int unsigned DBIT    = UART_DBIT,
    parameter int unsigned SB_TICK = UART_SB_TICK,
    parameter int unsigned ADDR_W  = UART_ADDR_W
) (
    input  logic            clk,
    input  logic            reset_pin,
    input  logic            rx,
    input  logic            rd_rx_pin,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            rx_busy,
    output logic            frame_err,
    output logic            overrun
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic            rx_done_c;
    logic [DBIT-1:0] rx_byte;

    logic              rd_s1_q, rd_s2_q, rd_prev_q;
    logic              pop_c, push_c;
    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [DBIT-1:0]   mem_d [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              overrun_q, overrun_d;
    logic [DBIT-1:0]   r_data_q, r_data_d;

    uart_rx_core #(
        .DVSR    (DVSR),
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) u_core (
        .clk       (clk),
        .rst_n     (reset_pin),
        .rx        (rx),
        .rx_done_c (rx_done_c),
        .dout      (rx_byte),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
    always_comb begin
        pop_c     = rd_prev_q & ~rd_s2_q & ~empty_q;
        push_c    = rx_done_c & (~full_q | pop_c);
        overrun_d = overrun_q | (rx_done_c & full_q & ~pop_c);

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_c) begin
            mem_d[wptr_q] = rx_byte;
            wptr_d        = wptr_q + ADDR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_W'(DEPTH));
        r_data_d = mem_d[rptr_d];
    end

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            rd_s1_q   <= 1'b1;
            rd_s2_q   <= 1'b1;
            rd_prev_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            rd_s1_q   <= rd_rx_pin;
            rd_s2_q   <= rd_s1_q;
            rd_prev_q <= rd_s2_q;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            r_data_q  <= r_data_d;
        end
    end

    assign r_data   = r_data_q;
    assign rx_empty = empty_q;
    assign rx_full  = full_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with DVSR=4 (64 clocks per bit).
module tb_uart_rx_fifo;

    localparam int unsigned BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset_pin;
    logic       rx;
    logic       rd_rx_pin;
    logic [7:0] r_data;
    logic       rx_empty, rx_full, rx_busy, frame_err, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(
        .DVSR    (4),
        .DBIT    (8),
        .SB_TICK (16),
        .ADDR_W  (2)
    ) dut (
        .clk       (clk),
        .reset_pin (reset_pin),
        .rx        (rx),
        .rd_rx_pin (rd_rx_pin),
        .r_data    (r_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic drive_bit(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Full frame; stop_v=0 holds the stop bit low through its sample point, then idles high
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pop_in_stop);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        if (pop_in_stop) begin
            rx        = stop_v;
            rd_rx_pin = 1'b0;
            repeat (8) @(negedge clk);
            rd_rx_pin = 1'b1;
            repeat (BIT_CLKS - 8) @(negedge clk);
        end else if (!stop_v) begin
            drive_bit(1'b0, 48);
            drive_bit(1'b1, 16);
        end else begin
            drive_bit(1'b1, BIT_CLKS);
        end
    endtask

    task automatic do_pop();
        rd_rx_pin = 1'b0;
        repeat (4) @(negedge clk);
        rd_rx_pin = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_pin = 1'b0;
        rx        = 1'b1;
        rd_rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        reset_pin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_pin = 1'b0;
        rx        = 1'b1;
        rd_rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (r_data !== 8'h00) begin n_fail++; $display("FAIL reset_r_data: got %h expected 00", r_data); end
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
        if (rx_full !== 1'b0) begin n_fail++; $display("FAIL reset_rx_full: got %b expected 0", rx_full); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset_pin = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        d  = 8'h41;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL busy_before_3clk: got %b expected 0", rx_busy); end
        @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_3clk: got %b expected 1", rx_busy); end
        repeat (BIT_CLKS - 3) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        n_checks += 3;
        if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", rx_empty); end
        if (r_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h expected 41", r_data); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", rx_busy); end
        do_pop();
        n_checks++;
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty: got %b expected 1", rx_empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp[0] = 8'h08; exp[1] = 8'h28; exp[2] = 8'hFF; exp[3] = 8'h00;
        apply_reset();
        for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1, 1'b0);
        n_checks += 2;
        if (rx_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b expected 1", rx_full); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b expected 0", overrun); end
        send_frame(8'h55, 1'b1, 1'b0);
        n_checks += 2;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        if (rx_full !== 1'b1) begin n_fail++; $display("FAIL overrun_still_full: got %b expected 1", rx_full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (r_data !== exp[i]) begin n_fail++; $display("FAIL b2b_pop%0d: got %h expected %h", i, r_data, exp[i]); end
            do_pop();
        end
        n_checks++;
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL overrun_dropped: got empty=%b data=%h expected empty=1", rx_empty, r_data); end
    endtask

    task automatic test_pop_in_stop();
        logic [7:0] exp [4];
        exp[0] = 8'h28; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h55;
        apply_reset();
        send_frame(8'h08, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, 1'b0);
        n_checks++;
        if (r_data !== 8'h08) begin n_fail++; $display("FAIL stop_pop_head: got %h expected 08", r_data); end
        send_frame(8'h55, 1'b1, 1'b1);
        n_checks += 2;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL stop_pop_no_overrun: got %b expected 0", overrun); end
        if (rx_full !== 1'b1) begin n_fail++; $display("FAIL stop_pop_full: got %b expected 1", rx_full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (r_data !== exp[i]) begin n_fail++; $display("FAIL stop_pop%0d: got %h expected %h", i, r_data, exp[i]); end
            do_pop();
        end
        n_checks++;
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL stop_pop_drained: got %b expected 1", rx_empty); end
    endtask

    task automatic test_glitch();
        drive_bit(1'b0, 12);
        rx = 1'b1;
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b expected 1", rx_busy); end
        repeat (200) @(negedge clk);
        n_checks += 3;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b expected 1", rx_empty); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        n_checks += 3;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_empty: got %b expected 1", rx_empty); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle: got %b expected 0", rx_busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h3C;
        send_frame(8'h77, 1'b1, 1'b0);
        n_checks++;
        if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL mid_prefill: got %b expected 0", rx_empty); end
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT_CLKS);
        drive_bit(d[3], 20);
        reset_pin = 1'b0;
        #1;
        n_checks += 6;
        if (r_data !== 8'h00) begin n_fail++; $display("FAIL mid_r_data: got %h expected 00", r_data); end
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rx_empty: got %b expected 1", rx_empty); end
        if (rx_full !== 1'b0) begin n_fail++; $display("FAIL mid_rx_full: got %b expected 0", rx_full); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rx_busy: got %b expected 0", rx_busy); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_frame_err: got %b expected 0", frame_err); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun: got %b expected 0", overrun); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_pin = 1'b1;
        repeat (100) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0);
        n_checks += 3;
        if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty: got %b expected 0", rx_empty); end
        if (r_data !== 8'h12) begin n_fail++; $display("FAIL post_reset_data: got %h expected 12", r_data); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL post_reset_ferr: got %b expected 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_pop_in_stop();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
